// File: rtl/core_pkg.sv
// Shared definitions for the fetch stage: PC select codes and default vectors.
package core_pkg;

    // Next-PC source selected by the control unit
    typedef enum logic [1:0] {
        PC_SEL_SEQ = 2'b00,
        PC_SEL_REL = 2'b01,
        PC_SEL_ABS = 2'b10,
        PC_SEL_RAS = 2'b11
    } pc_sel_e;

    localparam int unsigned DEFAULT_XLEN         = 32;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_1000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;
    localparam int unsigned DEFAULT_RAS_DEPTH    = 4;

    // A fetch target must be word aligned; any set low bit is a fault
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return |low_bits;
    endfunction

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack. When full, a push overwrites the oldest
// entry and the count saturates at DEPTH. Pop of an empty stack is ignored.
// A simultaneous push and pop replaces the top entry in place.
module return_addr_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [XLEN-1:0]          wdata,
    output logic [XLEN-1:0]          rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  mem_q [DEPTH];
    logic [XLEN-1:0]  mem_d [DEPTH];
    logic [PTR_W-1:0] top_q, top_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_ok;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CNT_W'(DEPTH));
    assign rdata  = mem_q[top_q];
    assign count  = count_q;
    assign pop_ok = pop && !empty;

    // Next pointer, count and storage contents for push, pop or replace
    always_comb begin
        mem_d   = mem_q;
        top_d   = top_q;
        count_d = count_q;
        if (push && pop_ok) begin
            mem_d[top_q] = wdata;
        end else if (push) begin
            top_d        = top_q + PTR_W'(1);
            mem_d[top_d] = wdata;
            if (!full) begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (pop_ok) begin
            top_d   = top_q - PTR_W'(1);
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointer and occupancy registers; contents after reset are don't-care
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            top_q   <= '0;
            count_q <= '0;
        end else begin
            top_q   <= top_d;
            count_q <= count_d;
        end
    end

    // Stack storage, not reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/program_counter_ras.sv
// Fetch PC generator: selects sequential, relative, absolute or RAS-pop
// targets, redirects to the trap vector on request or misaligned target,
// and maintains a return-address stack for calls and returns.
module program_counter_ras
    import core_pkg::*;
#(
    parameter int unsigned     XLEN         = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR),
    parameter int unsigned     RAS_DEPTH    = DEFAULT_RAS_DEPTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic                        trap_req,
    input  logic [1:0]                  pc_sel,
    input  logic [XLEN-1:0]             imm,
    input  logic [XLEN-1:0]             base,
    input  logic                        ras_push,
    output logic [XLEN-1:0]             pc_out,
    output logic [XLEN-1:0]             pc_plus4,
    output logic [$clog2(RAS_DEPTH):0]  ras_count,
    output logic                        misalign_err,
    output logic                        ras_underflow
);

    pc_sel_e          sel;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             misalign_err_q, misalign_err_d;
    logic             ras_underflow_q, ras_underflow_d;
    logic [XLEN-1:0]  tgt;
    logic [XLEN-1:0]  abs_sum;
    logic             checked_sel;
    logic             empty_pop;
    logic             misaligned;
    logic             advance;
    logic             ras_push_eff;
    logic             ras_pop_eff;
    logic [XLEN-1:0]  ras_rdata;
    logic             ras_empty;
    logic             ras_full;

    assign sel      = pc_sel_e'(pc_sel);
    assign pc_plus4 = pc_q + XLEN'(4);
    assign abs_sum  = base + imm;

    // Target mux; only relative and absolute targets are alignment checked
    always_comb begin
        tgt         = pc_plus4;
        checked_sel = 1'b0;
        empty_pop   = 1'b0;
        case (sel)
            PC_SEL_SEQ: tgt = pc_plus4;
            PC_SEL_REL: begin
                tgt         = pc_q + imm;
                checked_sel = 1'b1;
            end
            PC_SEL_ABS: begin
                tgt         = {abs_sum[XLEN-1:1], 1'b0};
                checked_sel = 1'b1;
            end
            PC_SEL_RAS: begin
                if (ras_empty) begin
                    tgt       = pc_plus4;
                    empty_pop = 1'b1;
                end else begin
                    tgt = ras_rdata;
                end
            end
            default: tgt = pc_plus4;
        endcase
    end

    assign misaligned   = checked_sel && is_misaligned(tgt[1:0]);
    assign advance      = en && !trap_req;
    assign ras_push_eff = advance && !misaligned && ras_push;
    assign ras_pop_eff  = advance && !misaligned && (sel == PC_SEL_RAS);

    // Next PC and status pulses; trap beats stall beats normal advance
    always_comb begin
        pc_d            = pc_q;
        misalign_err_d  = 1'b0;
        ras_underflow_d = 1'b0;
        if (trap_req) begin
            pc_d = TRAP_VECTOR;
        end else if (en) begin
            if (misaligned) begin
                pc_d           = TRAP_VECTOR;
                misalign_err_d = 1'b1;
            end else begin
                pc_d            = tgt;
                ras_underflow_d = empty_pop;
            end
        end
    end

    // PC register and one-cycle status pulse flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q            <= RESET_VECTOR;
            misalign_err_q  <= 1'b0;
            ras_underflow_q <= 1'b0;
        end else begin
            pc_q            <= pc_d;
            misalign_err_q  <= misalign_err_d;
            ras_underflow_q <= ras_underflow_d;
        end
    end

    return_addr_stack #(
        .DEPTH (RAS_DEPTH),
        .XLEN  (XLEN)
    ) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (ras_push_eff),
        .pop   (ras_pop_eff),
        .wdata (pc_plus4),
        .rdata (ras_rdata),
        .count (ras_count),
        .empty (ras_empty),
        .full  (ras_full)
    );

    assign pc_out        = pc_q;
    assign misalign_err  = misalign_err_q;
    assign ras_underflow = ras_underflow_q;

endmodule

// File: tb/tb_program_counter_ras.sv
// Bench for program_counter_ras: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a queue-based model.
module tb_program_counter_ras;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RV    = 32'h0000_1000;
    localparam logic [31:0] TV    = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        trap_req;
    logic [1:0]  pc_sel;
    logic [31:0] imm;
    logic [31:0] base;
    logic        ras_push;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic [2:0]  ras_count;
    logic        misalign_err;
    logic        ras_underflow;

    int checks = 0;
    int passed = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    logic        m_mis;
    logic        m_und;

    program_counter_ras #(
        .XLEN         (32),
        .RESET_VECTOR (RV),
        .TRAP_VECTOR  (TV),
        .RAS_DEPTH    (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .trap_req      (trap_req),
        .pc_sel        (pc_sel),
        .imm           (imm),
        .base          (base),
        .ras_push      (ras_push),
        .pc_out        (pc_out),
        .pc_plus4      (pc_plus4),
        .ras_count     (ras_count),
        .misalign_err  (misalign_err),
        .ras_underflow (ras_underflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a PC value plus a queue of return addresses (back = top)
    always @(posedge clk or posedge reset) begin : model
        logic [31:0] tgt;
        logic        bad;
        logic        popped;
        logic [31:0] old_plus4;
        if (reset) begin
            m_pc = RV;
            m_ras.delete();
            m_mis = 1'b0;
            m_und = 1'b0;
        end else begin
            m_mis     = 1'b0;
            m_und     = 1'b0;
            old_plus4 = m_pc + 32'd4;
            if (trap_req) begin
                m_pc = TV;
            end else if (en) begin
                bad    = 1'b0;
                popped = 1'b0;
                case (pc_sel)
                    2'b00: tgt = old_plus4;
                    2'b01: begin tgt = m_pc + imm; bad = (tgt % 4) != 0; end
                    2'b10: begin tgt = (base + imm) & 32'hFFFF_FFFE; bad = (tgt % 4) != 0; end
                    default: begin
                        if (m_ras.size() == 0) begin
                            tgt   = old_plus4;
                            m_und = 1'b1;
                        end else begin
                            tgt    = m_ras[m_ras.size()-1];
                            popped = 1'b1;
                        end
                    end
                endcase
                if (bad) begin
                    m_pc  = TV;
                    m_mis = 1'b1;
                end else begin
                    m_pc = tgt;
                    if (popped && ras_push) begin
                        m_ras[m_ras.size()-1] = old_plus4;
                    end else begin
                        if (popped) void'(m_ras.pop_back());
                        if (ras_push) begin
                            m_ras.push_back(old_plus4);
                            if (m_ras.size() > DEPTH) m_ras.delete(0);
                        end
                    end
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("pc_out", pc_out, m_pc);
            checkOutput("pc_plus4", pc_plus4, m_pc + 32'd4);
            checkOutput("ras_count", 32'(ras_count), 32'(m_ras.size()));
            checkOutput("misalign_err", 32'(misalign_err), 32'(m_mis));
            checkOutput("ras_underflow", 32'(ras_underflow), 32'(m_und));
        end
    end

    // Drive one cycle of inputs and return at the following falling edge
    task automatic applyStimulus(input logic e, input logic t, input logic [1:0] s,
                                 input logic [31:0] im, input logic [31:0] b, input logic p);
        en       = e;
        trap_req = t;
        pc_sel   = s;
        imm      = im;
        base     = b;
        ras_push = p;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] exp_pops [4];
        reset    = 1'b1;
        en       = 1'b0;
        trap_req = 1'b0;
        pc_sel   = 2'b00;
        imm      = '0;
        base     = '0;
        ras_push = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;

        checkOutput("reset pc", pc_out, 32'h1000);
        checkOutput("reset count", 32'(ras_count), 32'd0);
        checkOutput("reset pulses", {30'd0, misalign_err, ras_underflow}, 32'd0);

        // Sequential fetch
        applyStimulus(1, 0, 2'b00, 0, 0, 0);
        checkOutput("seq1", pc_out, 32'h1004);
        applyStimulus(1, 0, 2'b00, 0, 0, 0);
        checkOutput("seq2", pc_out, 32'h1008);
        applyStimulus(1, 0, 2'b00, 0, 0, 0);
        checkOutput("seq3", pc_out, 32'h100C);

        // Relative branch, then misaligned relative target
        applyStimulus(1, 0, 2'b01, 32'hFFFF_FFF8, 0, 0);
        checkOutput("rel back", pc_out, 32'h1004);
        applyStimulus(1, 0, 2'b01, 32'd2, 0, 0);
        checkOutput("misalign pc", pc_out, 32'h100);
        checkOutput("misalign pulse", 32'(misalign_err), 32'd1);
        applyStimulus(1, 0, 2'b10, 0, 32'h1004, 0);
        checkOutput("misalign cleared", 32'(misalign_err), 32'd0);

        // Call via JALR with bit0 masked, return, then empty return
        applyStimulus(1, 0, 2'b10, 0, 32'h2001, 1);
        checkOutput("call pc", pc_out, 32'h2000);
        checkOutput("call count", 32'(ras_count), 32'd1);
        applyStimulus(1, 0, 2'b11, 0, 0, 0);
        checkOutput("ret pc", pc_out, 32'h1008);
        checkOutput("ret count", 32'(ras_count), 32'd0);
        applyStimulus(1, 0, 2'b11, 0, 0, 0);
        checkOutput("underflow pc", pc_out, 32'h100C);
        checkOutput("underflow pulse", 32'(ras_underflow), 32'd1);

        // Five calls into a four-deep stack, then five returns
        repeat (5) applyStimulus(1, 0, 2'b00, 0, 0, 1);
        checkOutput("full count", 32'(ras_count), 32'd4);
        exp_pops = '{32'h1020, 32'h101C, 32'h1018, 32'h1014};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 2'b11, 0, 0, 0);
            checkOutput("pop pc", pc_out, exp_pops[i]);
            checkOutput("pop count", 32'(ras_count), 32'(3 - i));
        end
        applyStimulus(1, 0, 2'b11, 0, 0, 0);
        checkOutput("pop5 underflow", 32'(ras_underflow), 32'd1);
        checkOutput("pop5 count", 32'(ras_count), 32'd0);
        checkOutput("pop5 pc", pc_out, 32'h1018);

        // Stall holds everything; trap overrides stall
        repeat (3) applyStimulus(1, 0, 2'b00, 0, 0, 1);
        repeat (3) applyStimulus(0, 0, 2'b01, 32'd8, 0, 1);
        checkOutput("stall pc", pc_out, 32'h1024);
        checkOutput("stall count", 32'(ras_count), 32'd3);
        applyStimulus(0, 1, 2'b00, 0, 0, 0);
        checkOutput("trap pc", pc_out, 32'h100);
        checkOutput("trap count", 32'(ras_count), 32'd3);

        // Asynchronous reset in the middle of the low phase
        #2 reset = 1'b1;
        #1;
        checkOutput("async reset pc", pc_out, 32'h1000);
        checkOutput("async reset count", 32'(ras_count), 32'd0);
        @(negedge clk);
        #2 reset = 1'b0;

        // Address wrap at the top of the space
        applyStimulus(1, 0, 2'b10, 0, 32'hFFFF_FFFC, 0);
        checkOutput("top pc", pc_out, 32'hFFFF_FFFC);
        checkOutput("top plus4", pc_plus4, 32'h0);
        applyStimulus(1, 0, 2'b00, 0, 0, 0);
        checkOutput("wrap pc", pc_out, 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            r = 32'($urandom_range(0, 64)) - 32'd32;
            r = r << 2;
            if ($urandom_range(0, 7) == 0) r = r + 32'($urandom_range(1, 3));
            base = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 5) == 0) base = base | 32'($urandom_range(1, 3));
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                          2'($urandom_range(0, 3)), r, base, $urandom_range(0, 2) == 0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
